mor1kx_tlb_reload_arbiter: RTL and testbench
============================================

// Module: mor1kx_tlb_reload_arbiter
// PURPOSE
//  Shares one memory read port between the IMMU and DMMU hardware TLB-reload walkers.
//  Each walker issues single-word reads (PTE pointer, then PTE) on its tlb_reload_* handshake.
//  The block grants ownership, sequences bus beats, registers response data and acks the owner.
//  It also enforces a bus timeout. Sits between the MMUs and the CPU's load/store bus bridge.
// PARAMETERS
//  OPTION_OPERAND_WIDTH  32            address/data width
//  ARB_POLICY            "ROUNDROBIN"  "ROUNDROBIN" or "DMMU_FIRST" (fixed priority, DMMU wins)
//  TIMEOUT_CYCLES        255           bus_req_o cycles without ack/err before forced error; 0 = off
// PORTS
//  clk           in   1      clock; all state on rising edge
//  rst           in   1      reset, synchronous, active-high
//  immu_req_i    in   1      IMMU reload request (held high across pointer+PTE beats)
//  immu_addr_i   in   OW     IMMU word address, stable while req high within a beat
//  immu_ack_o    out  1      one-cycle response strobe to IMMU
//  immu_data_o   out  OW     response data, valid with immu_ack_o
//  immu_err_o    out  1      bus error/timeout, valid with immu_ack_o
//  dmmu_req_i / dmmu_addr_i / dmmu_ack_o / dmmu_data_o / dmmu_err_o   same, DMMU side
//  bus_req_o     out  1      read request to memory port
//  bus_addr_o    out  OW     read address
//  bus_ack_i     in   1      read complete, bus_dat_i valid
//  bus_err_i     in   1      read terminated with error
//  bus_dat_i     in   OW     read data
//  busy_o        out  1      any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; bus_req_o, all *_ack_o, all *_err_o and busy_o are 0.
//   Data outputs and bus_addr_o are 0. owner=IMMU. last_grant=DMMU, so the first RR tie goes to IMMU.
//  FSM states: IDLE, BUS, RESP, DRAIN.
//  IDLE: if any req high, pick owner.
//   RR: the requester not in last_grant wins a tie. DMMU_FIRST: DMMU wins a tie.
//   Register bus_addr_o from the owner's addr. Go to BUS; bus_req_o=1 from the next cycle.
//  BUS: bus_req_o=1, bus_addr_o held.
//   On bus_ack_i|bus_err_i: capture bus_dat_i and err=bus_err_i&!bus_ack_i (ack wins if both).
//    Clear timeout counter. Go to RESP.
//   If owner req drops while in BUS: go to DRAIN; the outstanding beat is not cancelled.
//   Timeout counter increments each BUS cycle.
//    At TIMEOUT_CYCLES: data=0, err=1, bus_req_o drops, go to RESP.
//  DRAIN: bus_req_o stays 1 until bus_ack_i|bus_err_i or timeout. Response discarded, no owner ack.
//   Then go to IDLE and set last_grant=owner.
//  RESP: owner *_ack_o=1 for exactly one cycle with registered data/err; bus_req_o=0.
//   The other requester's ack/err outputs stay 0.
//   Next cycle: owner req still high -> BUS, re-sampling owner addr (second beat, new address).
//   Owner req low -> last_grant=owner and re-arbitrate as in IDLE in the same cycle (no dead cycle).
//  Ownership is never preempted while owner req stays high. The other requester waits.
//  Latency: req rise -> bus_req_o 1 cycle; bus_ack_i -> owner ack 1 cycle.
//  bus_req_o always drops for >=1 cycle between beats (RESP turnaround).
//  bus_addr_o changes only on entry to BUS.
//  Simultaneous bus_ack_i and owner req fall in BUS: the beat counts as completed and RESP pulses.
//   The requester ignores it.
//  Reset mid-beat: bus_req_o drops next edge. The bus side must tolerate an abandoned request.
//  Acks arriving while not in BUS/DRAIN are ignored.
// STRUCTURE
//  FSM encodings and default TIMEOUT go in mor1kx-defines.v (`OR1K_TLBARB_* localparams).
//  One sub-module: mor1kx_arb_rr2, 2-way arbiter with last-grant pointer and fixed-priority option.
//   It is reusable for other dual-requester ports. The rest is flat.
// TESTING
//  1. Single IMMU walk: addr 0x1000_0040, ack after 3 cycles, data 0x0002_2001.
//     Then req held, addr 0x0002_2010, ack, data 0x0003_3401.
//     -> two immu_ack_o pulses with those data; bus_req_o low exactly 1 cycle between beats.
//  2. Both req rise same cycle after reset, RR.
//     -> IMMU granted first; DMMU granted in the cycle after IMMU drops req; dmmu_ack_o never seen early.
//  3. DMMU_FIRST, both req rise together -> DMMU walk completes first, IMMU served after.
//  4. Owner drops req 2 cycles into BUS; bus_ack_i 4 cycles later.
//     -> bus_req_o held to ack, no immu_ack_o, state IDLE next cycle.
//  5. TIMEOUT_CYCLES=8, no ack -> after 8 BUS cycles bus_req_o=0, owner ack with err=1, data=0.
//     Also: bus_err_i alone -> err=1; bus_err_i&bus_ack_i -> err=0.
//  6. rst asserted in BUS mid-walk -> next cycle bus_req_o=0, all acks 0, busy_o=0.
//     First grant after reset goes to IMMU.

Source files
------------

// File: rtl/mor1kx_tlb_reload_arbiter_pkg.sv
// Shared definitions for the TLB-reload arbiter: FSM encodings, the default
// bus timeout and a helper that sizes the timeout counter.
package mor1kx_tlb_reload_arbiter_pkg;

  localparam logic [1:0] OR1K_TLBARB_IDLE  = 2'd0;
  localparam logic [1:0] OR1K_TLBARB_BUS   = 2'd1;
  localparam logic [1:0] OR1K_TLBARB_RESP  = 2'd2;
  localparam logic [1:0] OR1K_TLBARB_DRAIN = 2'd3;

  localparam int OR1K_TLBARB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = OR1K_TLBARB_IDLE,
    ST_BUS   = OR1K_TLBARB_BUS,
    ST_RESP  = OR1K_TLBARB_RESP,
    ST_DRAIN = OR1K_TLBARB_DRAIN
  } tlbarb_state_e;

  typedef enum logic {
    OWN_IMMU = 1'b0,
    OWN_DMMU = 1'b1
  } tlbarb_owner_e;

  // Counter width able to hold TIMEOUT-1; at least one bit so a disabled
  // timeout (0) still yields a legal vector.
  function automatic int tlbarb_cnt_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/mor1kx_arb_rr2.sv
// Two-way arbiter with a last-grant pointer.
//  clk, rst   : clock, synchronous active-high reset
//  req[1:0]   : request vector
//  commit     : a grant is being taken this cycle; pointer follows the winner
//  gnt_idx    : index of the winning requester (meaningful when |req)
// With FIXED_PRIO=1 requester 1 always wins a tie; otherwise a tie goes to the
// requester that was not granted last. Reset leaves the pointer on index 1,
// so the first tie after reset goes to index 0.
module mor1kx_arb_rr2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       commit,
  output logic       gnt_idx
);

  logic last;

  always_comb begin
    gnt_idx = req[1];
    if (req == 2'b11) gnt_idx = FIXED_PRIO ? 1'b1 : ~last;
  end

  always_ff @(posedge clk) begin
    if (rst)                  last <= 1'b1;
    else if (commit && |req)  last <= gnt_idx;
  end

endmodule

// File: rtl/mor1kx_tlb_reload_arbiter.sv
// Shares one memory read port between the IMMU and DMMU TLB-reload walkers.
// A walker holds *_req_i across its pointer and PTE beats; each beat is one
// bus read whose registered result is returned with a one-cycle *_ack_o.
//  clk, rst                       : clock, synchronous active-high reset
//  immu_req_i/addr_i              : IMMU walker request and word address
//  immu_ack_o/data_o/err_o        : IMMU response strobe, data, error
//  dmmu_*                         : same, DMMU side
//  bus_req_o/addr_o               : read request to the memory port
//  bus_ack_i/err_i/dat_i          : read completion, error, data
//  busy_o                         : FSM is not idle
module mor1kx_tlb_reload_arbiter
  import mor1kx_tlb_reload_arbiter_pkg::*;
#(
  parameter int    OPTION_OPERAND_WIDTH = 32,
  parameter string ARB_POLICY           = "ROUNDROBIN",
  parameter int    TIMEOUT_CYCLES       = OR1K_TLBARB_TIMEOUT_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            immu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
  output logic                            immu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
  output logic                            immu_err_o,
  input  logic                            dmmu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
  output logic                            dmmu_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
  output logic                            dmmu_err_o,
  output logic                            bus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] bus_addr_o,
  input  logic                            bus_ack_i,
  input  logic                            bus_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i,
  output logic                            busy_o
);

  localparam int OW = OPTION_OPERAND_WIDTH;
  localparam bit FIXED_PRIO = (ARB_POLICY == "DMMU_FIRST");
  localparam int CW = tlbarb_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  tlbarb_state_e state;
  tlbarb_owner_e owner;
  logic [CW-1:0] to_cnt;

  logic          win;
  logic          any_req, owner_req, bus_done, to_hit, arb_commit;
  logic [OW-1:0] win_addr, owner_addr;
  logic          rsp_err;
  logic [OW-1:0] rsp_data;

  assign any_req    = immu_req_i | dmmu_req_i;
  assign owner_req  = (owner == OWN_DMMU) ? dmmu_req_i  : immu_req_i;
  assign owner_addr = (owner == OWN_DMMU) ? dmmu_addr_i : immu_addr_i;
  assign win_addr   = win ? dmmu_addr_i : immu_addr_i;
  assign bus_done   = bus_ack_i | bus_err_i;
  // to_cnt counts completed request cycles, so hitting TIMEOUT-1 means this
  // is the TIMEOUT-th cycle with bus_req_o high and no completion.
  assign to_hit     = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
  // A real completion beats the timeout; ack wins over err when both arrive.
  assign rsp_err    = bus_done ? (bus_err_i & ~bus_ack_i) : 1'b1;
  assign rsp_data   = bus_done ? bus_dat_i : '0;

  // New ownership is taken from IDLE, or straight out of RESP once the owner
  // has let go, so the other walker sees no dead cycle.
  assign arb_commit = any_req &&
                      ((state == ST_IDLE) || ((state == ST_RESP) && !owner_req));

  // Pointer moves at grant time; since ownership is never preempted this is
  // equivalent to recording the owner when its walk ends.
  mor1kx_arb_rr2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({dmmu_req_i, immu_req_i}),
    .commit  (arb_commit),
    .gnt_idx (win)
  );

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= OWN_IMMU;
      to_cnt      <= '0;
      bus_req_o   <= 1'b0;
      bus_addr_o  <= '0;
      immu_ack_o  <= 1'b0;
      immu_err_o  <= 1'b0;
      immu_data_o <= '0;
      dmmu_ack_o  <= 1'b0;
      dmmu_err_o  <= 1'b0;
      dmmu_data_o <= '0;
    end else begin
      immu_ack_o <= 1'b0;
      immu_err_o <= 1'b0;
      dmmu_ack_o <= 1'b0;
      dmmu_err_o <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          bus_req_o <= 1'b0;
          to_cnt    <= '0;
          if ((state == ST_RESP) && owner_req) begin
            // Owner continues its walk: next beat at its new address.
            bus_addr_o <= owner_addr;
            bus_req_o  <= 1'b1;
            state      <= ST_BUS;
          end else if (any_req) begin
            owner      <= tlbarb_owner_e'(win);
            bus_addr_o <= win_addr;
            bus_req_o  <= 1'b1;
            state      <= ST_BUS;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUS: begin
          if (bus_done || to_hit) begin
            // Completion is reported even if the owner dropped req this
            // same cycle; the walker simply ignores it.
            state     <= ST_RESP;
            bus_req_o <= 1'b0;
            to_cnt    <= '0;
            if (owner == OWN_DMMU) begin
              dmmu_ack_o  <= 1'b1;
              dmmu_err_o  <= rsp_err;
              dmmu_data_o <= rsp_data;
            end else begin
              immu_ack_o  <= 1'b1;
              immu_err_o  <= rsp_err;
              immu_data_o <= rsp_data;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
            // The outstanding read cannot be withdrawn; wait it out quietly.
            if (!owner_req) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus_done || to_hit) begin
            state     <= ST_IDLE;
            bus_req_o <= 1'b0;
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bus_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mor1kx_tlb_reload_arbiter.sv
// Bench for mor1kx_tlb_reload_arbiter: directed scenarios on a round-robin
// and a DMMU-first instance sharing inputs, then random two-beat walks from
// both walkers against a behavioural memory/bus model.
module tb_mor1kx_tlb_reload_arbiter;

  localparam int OW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          immu_req = 1'b0, dmmu_req = 1'b0;
  logic [OW-1:0] immu_addr = '0, dmmu_addr = '0;
  logic          bus_ack = 1'b0, bus_err = 1'b0;
  logic [OW-1:0] bus_dat = '0;

  logic          rr_immu_ack, rr_immu_err, rr_dmmu_ack, rr_dmmu_err, rr_bus_req, rr_busy;
  logic [OW-1:0] rr_immu_data, rr_dmmu_data, rr_bus_addr;
  logic          fp_immu_ack, fp_immu_err, fp_dmmu_ack, fp_dmmu_err, fp_bus_req, fp_busy;
  logic [OW-1:0] fp_immu_data, fp_dmmu_data, fp_bus_addr;

  bit use_fp = 1'b0;
  bit rnd_done = 1'b0;

  logic          o_immu_ack, o_immu_err, o_dmmu_ack, o_dmmu_err, o_bus_req, o_busy;
  logic [OW-1:0] o_immu_data, o_dmmu_data, o_bus_addr;
  assign o_immu_ack  = use_fp ? fp_immu_ack  : rr_immu_ack;
  assign o_immu_err  = use_fp ? fp_immu_err  : rr_immu_err;
  assign o_immu_data = use_fp ? fp_immu_data : rr_immu_data;
  assign o_dmmu_ack  = use_fp ? fp_dmmu_ack  : rr_dmmu_ack;
  assign o_dmmu_err  = use_fp ? fp_dmmu_err  : rr_dmmu_err;
  assign o_dmmu_data = use_fp ? fp_dmmu_data : rr_dmmu_data;
  assign o_bus_req   = use_fp ? fp_bus_req   : rr_bus_req;
  assign o_bus_addr  = use_fp ? fp_bus_addr  : rr_bus_addr;
  assign o_busy      = use_fp ? fp_busy      : rr_busy;

  mor1kx_tlb_reload_arbiter #(
    .OPTION_OPERAND_WIDTH (OW), .ARB_POLICY ("ROUNDROBIN"), .TIMEOUT_CYCLES (TO)
  ) dut_rr (
    .clk (clk), .rst (rst),
    .immu_req_i (immu_req), .immu_addr_i (immu_addr),
    .immu_ack_o (rr_immu_ack), .immu_data_o (rr_immu_data), .immu_err_o (rr_immu_err),
    .dmmu_req_i (dmmu_req), .dmmu_addr_i (dmmu_addr),
    .dmmu_ack_o (rr_dmmu_ack), .dmmu_data_o (rr_dmmu_data), .dmmu_err_o (rr_dmmu_err),
    .bus_req_o (rr_bus_req), .bus_addr_o (rr_bus_addr),
    .bus_ack_i (bus_ack), .bus_err_i (bus_err), .bus_dat_i (bus_dat),
    .busy_o (rr_busy)
  );

  mor1kx_tlb_reload_arbiter #(
    .OPTION_OPERAND_WIDTH (OW), .ARB_POLICY ("DMMU_FIRST"), .TIMEOUT_CYCLES (TO)
  ) dut_fp (
    .clk (clk), .rst (rst),
    .immu_req_i (immu_req), .immu_addr_i (immu_addr),
    .immu_ack_o (fp_immu_ack), .immu_data_o (fp_immu_data), .immu_err_o (fp_immu_err),
    .dmmu_req_i (dmmu_req), .dmmu_addr_i (dmmu_addr),
    .dmmu_ack_o (fp_dmmu_ack), .dmmu_data_o (fp_dmmu_data), .dmmu_err_o (fp_dmmu_err),
    .bus_req_o (fp_bus_req), .bus_addr_o (fp_bus_addr),
    .bus_ack_i (bus_ack), .bus_err_i (bus_err), .bus_dat_i (bus_dat),
    .busy_o (fp_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model: contents are a fixed scramble of the address. Addresses with
  // [3:2]==3 answer with an error; with [4] also set, ack and err arrive
  // together and the read counts as good.
  function automatic logic [OW-1:0] mem_rd(input logic [OW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic exp_err(input logic [OW-1:0] a);
    return (a[3:2] == 2'b11) && !a[4];
  endfunction
  // IMMU addresses live in the low half, DMMU in the high half.
  function automatic logic [OW-1:0] gen_addr(input bit side);
    logic [OW-1:0] r;
    r = $urandom();
    return {side, r[30:2], 2'b00};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic respond(input logic a, input logic e, input logic [OW-1:0] d);
    bus_ack = a; bus_err = e; bus_dat = d;
    step();
    bus_ack = 1'b0; bus_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; immu_req = 1'b0; dmmu_req = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    step(); step();
    chk("rst_bus_req", o_bus_req, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_acks", {o_immu_ack, o_dmmu_ack, o_immu_err, o_dmmu_err}, 0);
    chk("rst_bus_addr", o_bus_addr, 0);
    chk("rst_data", o_immu_data | o_dmmu_data, 0);
    rst = 1'b0;
  endtask

  // Both walkers raise req together; the policy decides who goes first.
  task automatic arb_pair(input bit fp, input logic [OW-1:0] ia, input logic [OW-1:0] da);
    bit w;
    w = fp;
    use_fp = fp;
    do_reset();
    immu_addr = ia; dmmu_addr = da; immu_req = 1'b1; dmmu_req = 1'b1;
    step();
    chk("arb_first_addr", o_bus_addr, w ? da : ia);
    respond(1'b1, 1'b0, mem_rd(w ? da : ia));
    chk("arb_first_ack", w ? o_dmmu_ack : o_immu_ack, 1);
    chk("arb_first_data", w ? o_dmmu_data : o_immu_data, mem_rd(w ? da : ia));
    chk("arb_other_quiet", w ? o_immu_ack : o_dmmu_ack, 0);
    if (w) dmmu_req = 1'b0; else immu_req = 1'b0;
    step();
    chk("arb_second_req", o_bus_req, 1);
    chk("arb_second_addr", o_bus_addr, w ? ia : da);
    respond(1'b1, 1'b0, mem_rd(w ? ia : da));
    chk("arb_second_ack", w ? o_immu_ack : o_dmmu_ack, 1);
    chk("arb_second_data", w ? o_immu_data : o_dmmu_data, mem_rd(w ? ia : da));
    immu_req = 1'b0; dmmu_req = 1'b0;
    step();
    chk("arb_idle", o_busy, 0);
  endtask

  task automatic sample(input bit side, output logic ak, output logic [OW-1:0] dt, output logic er);
    ak = side ? o_dmmu_ack  : o_immu_ack;
    dt = side ? o_dmmu_data : o_immu_data;
    er = side ? o_dmmu_err  : o_immu_err;
  endtask

  task automatic drive(input bit side, input logic rq, input logic [OW-1:0] a);
    if (side) begin dmmu_req = rq; dmmu_addr = a; end
    else      begin immu_req = rq; immu_addr = a; end
  endtask

  // A walker issues two-beat walks; occasionally it gives up during the first beat.
  task automatic walker(input bit side, input int nwalks);
    logic [OW-1:0] a, dt;
    logic          ak, er;
    int            ign, cyc, abort_at;
    bit            got, aborted, abort_en;
    string         p;
    p = side ? "d_" : "i_";
    ign = 0;
    for (int w = 0; w < nwalks; w++) begin
      repeat ($urandom_range(1, 3)) begin
        step();
        sample(side, ak, dt, er);
        if (ign > 0) ign--;
        else chk({p, "stray_ack"}, ak, 0);
      end
      abort_en = ($urandom_range(0, 7) == 0);
      abort_at = $urandom_range(1, 6);
      aborted  = 1'b0;
      a = gen_addr(side);
      drive(side, 1'b1, a);
      for (int beat = 0; beat < 2; beat++) begin
        got = 1'b0; cyc = 0;
        while (!got && cyc < 100) begin
          step(); cyc++;
          sample(side, ak, dt, er);
          if (ign > 0) begin ign--; continue; end
          if (ak) begin
            got = 1'b1;
            chk({p, "err"}, er, exp_err(a));
            if (!exp_err(a)) chk({p, "data"}, dt, mem_rd(a));
          end else if (abort_en && beat == 0 && cyc == abort_at) begin
            drive(side, 1'b0, a);
            ign = 2;
            aborted = 1'b1;
            break;
          end
        end
        if (aborted) break;
        if (!got) begin
          chk({p, "wait_budget"}, 0, 1);
          drive(side, 1'b0, a);
          break;
        end
        if (beat == 0) begin a = gen_addr(side); drive(side, 1'b1, a); end
        else drive(side, 1'b0, a);
      end
    end
  endtask

  // Bus slave: random latency 0..4 cycles after the request is first seen.
  task automatic responder();
    logic [OW-1:0] a;
    int            lat;
    bit            pend, just;
    pend = 1'b0; just = 1'b0; lat = 0; a = '0;
    while (!rnd_done) begin
      step();
      bus_ack = 1'b0; bus_err = 1'b0;
      if (just) begin
        chk("turnaround", o_bus_req, 0);
        just = 1'b0;
      end else if (o_bus_req) begin
        if (!pend) begin
          pend = 1'b1; a = o_bus_addr; lat = $urandom_range(0, 4);
        end else chk("addr_hold", o_bus_addr, a);
        if (lat == 0) begin
          bus_dat = mem_rd(a);
          if (a[3:2] == 2'b11) begin
            bus_err = 1'b1;
            bus_ack = a[4];
            if (!a[4]) bus_dat = $urandom();
          end else bus_ack = 1'b1;
          pend = 1'b0; just = 1'b1;
        end else lat--;
      end else pend = 1'b0;
    end
    bus_ack = 1'b0; bus_err = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "bench did not finish in time");
  end

  initial begin
    // Single IMMU walk, two beats.
    use_fp = 1'b0;
    do_reset();
    immu_req = 1'b1; immu_addr = 32'h1000_0040;
    step();
    chk("t1_req_lat", o_bus_req, 1);
    chk("t1_addr0", o_bus_addr, 32'h1000_0040);
    chk("t1_busy", o_busy, 1);
    step(); step();
    respond(1'b1, 1'b0, 32'h0002_2001);
    chk("t1_ack0", o_immu_ack, 1);
    chk("t1_data0", o_immu_data, 32'h0002_2001);
    chk("t1_err0", o_immu_err, 0);
    chk("t1_gap", o_bus_req, 0);
    immu_addr = 32'h0002_2010;
    step();
    chk("t1_ack_pulse", o_immu_ack, 0);
    chk("t1_req1", o_bus_req, 1);
    chk("t1_addr1", o_bus_addr, 32'h0002_2010);
    respond(1'b1, 1'b0, 32'h0003_3401);
    chk("t1_ack1", o_immu_ack, 1);
    chk("t1_data1", o_immu_data, 32'h0003_3401);
    immu_req = 1'b0;
    step();
    chk("t1_idle", o_busy, 0);
    chk("t1_req_off", o_bus_req, 0);

    // Arbitration under both policies.
    arb_pair(1'b0, 32'h0000_1100, 32'h8000_2200);
    arb_pair(1'b1, 32'h0000_3300, 32'h8000_4400);

    // Owner abandons its beat; the read is drained without a response.
    use_fp = 1'b0;
    do_reset();
    immu_req = 1'b1; immu_addr = 32'h2000_0100;
    step(); step();
    immu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_hold", o_bus_req, 1);
      chk("t4_noack", o_immu_ack, 0);
    end
    respond(1'b1, 1'b0, 32'h1111_2222);
    chk("t4_drop", o_bus_req, 0);
    chk("t4_idle", o_busy, 0);
    chk("t4_noack2", o_immu_ack, 0);
    immu_req = 1'b1; dmmu_req = 1'b1; dmmu_addr = 32'h8000_0500;
    step();
    chk("t4_rr_after_drain", o_bus_addr, 32'h8000_0500);
    respond(1'b1, 1'b0, 32'h0);
    immu_req = 1'b0; dmmu_req = 1'b0;
    step();
    respond(1'b1, 1'b1, 32'h0);
    chk("idle_ack_ignored", {o_immu_ack, o_dmmu_ack, o_busy}, 0);

    // Timeout, error-only and ack+err responses.
    do_reset();
    dmmu_req = 1'b1; dmmu_addr = 32'h8000_0008; bus_dat = 32'hDEAD_BEEF;
    for (int i = 0; i < TO; i++) begin
      step();
      chk("t5_req_hold", o_bus_req, 1);
    end
    step();
    chk("t5_to_drop", o_bus_req, 0);
    chk("t5_to_ack", o_dmmu_ack, 1);
    chk("t5_to_err", o_dmmu_err, 1);
    chk("t5_to_data", o_dmmu_data, 0);
    step();
    respond(1'b0, 1'b1, 32'h0000_1234);
    chk("t5_err_ack", o_dmmu_ack, 1);
    chk("t5_err_only", o_dmmu_err, 1);
    step();
    respond(1'b1, 1'b1, 32'hCAFE_F00D);
    chk("t5_both_ack", o_dmmu_ack, 1);
    chk("t5_both_err", o_dmmu_err, 0);
    chk("t5_both_data", o_dmmu_data, 32'hCAFE_F00D);
    dmmu_req = 1'b0;
    step();
    chk("t5_idle", o_busy, 0);

    // Reset in the middle of a beat.
    do_reset();
    immu_req = 1'b1; dmmu_req = 1'b1; immu_addr = 32'h0000_6600; dmmu_addr = 32'h8000_7700;
    step();
    chk("t6_req", o_bus_req, 1);
    rst = 1'b1;
    step();
    chk("t6_rst_req", o_bus_req, 0);
    chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_acks", {o_immu_ack, o_dmmu_ack}, 0);
    rst = 1'b0;
    step();
    chk("t6_first_grant", o_bus_addr, 32'h0000_6600);
    respond(1'b1, 1'b0, 32'h0);
    immu_req = 1'b0; dmmu_req = 1'b0;
    step();

    // Random concurrent walks.
    do_reset();
    rnd_done = 1'b0;
    fork
      responder();
    join_none
    fork
      walker(1'b0, 30);
      walker(1'b1, 30);
    join
    rnd_done = 1'b1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
